// File: rtl/ulpb_tx_pkg.sv
// Shared types and default sizing for the ULPB transmit request queue.
package ulpb_tx_pkg;

   localparam int DEF_DEPTH     = 4;
   localparam int DEF_ADDR_W    = 8;
   localparam int DEF_DATA_W    = 32;
   localparam int DEF_MAX_RETRY = 2;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_REQ      = 3'd1,
      S_REL      = 3'd2,
      S_WAIT_RES = 3'd3,
      S_RES_CLR  = 3'd4,
      S_RETIRE   = 3'd5
   } tx_state_e;

endpackage

// File: rtl/ulpb_sync2.sv
// Two-flop synchronizer for the node-side handshake and status lines.
module ulpb_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/ulpb_tx_queue.sv
// Transmit request queue: buffers (addr, data) messages and feeds them to the
// node over REQ/ACK, closing each transfer with the TX status handshake.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | waiting for a queued entry
// S_REQ      | REQ_OUT high, waiting for synchronized ACK
// S_REL      | REQ_OUT low, waiting for ACK to drop
// S_WAIT_RES | waiting for TX_SUCCESS or TX_FAIL
// S_RES_CLR  | TX_ACK high, waiting for status lines to drop
// S_RETIRE   | DONE pulse, head entry popped
module ulpb_tx_queue
   import ulpb_tx_pkg::*;
#(
   parameter int DEPTH     = DEF_DEPTH,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int MAX_RETRY = DEF_MAX_RETRY
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     PUSH,
   input  logic [ADDR_W-1:0]        PUSH_ADDR,
   input  logic [DATA_W-1:0]        PUSH_DATA,
   output logic                     FULL,
   output logic                     EMPTY,
   output logic [$clog2(DEPTH):0]   COUNT,
   output logic                     OVERFLOW,
   output logic [ADDR_W-1:0]        ADDR_OUT,
   output logic [DATA_W-1:0]        DATA_OUT,
   output logic                     REQ_OUT,
   input  logic                     ACK_IN,
   input  logic                     TX_SUCCESS,
   input  logic                     TX_FAIL,
   output logic                     TX_ACK,
   output logic                     DONE,
   output logic                     DONE_FAIL
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   logic [ADDR_W-1:0] mem_addr [DEPTH];
   logic [DATA_W-1:0] mem_data [DEPTH];
   logic [PW-1:0]     wptr;
   logic [PW-1:0]     rptr;
   logic [CW-1:0]     count_q;
   logic [CW-1:0]     count_nxt;
   logic [RW-1:0]     retry_cnt;
   logic              res_fail;
   logic              ack_s;
   logic              succ_s;
   logic              fail_s;
   logic              push_ok;
   logic              retire;
   logic              retry;
   tx_state_e         state;
   tx_state_e         state_nxt;

   ulpb_sync2 u_sync_ack  (.clk(CLK), .rst(RESET), .d(ACK_IN),     .q(ack_s));
   ulpb_sync2 u_sync_succ (.clk(CLK), .rst(RESET), .d(TX_SUCCESS), .q(succ_s));
   ulpb_sync2 u_sync_fail (.clk(CLK), .rst(RESET), .d(TX_FAIL),    .q(fail_s));

   assign push_ok  = PUSH && !FULL;
   assign COUNT    = count_q;
   assign ADDR_OUT = mem_addr[rptr];
   assign DATA_OUT = mem_data[rptr];

   always_comb begin
      state_nxt = state;
      retire    = 1'b0;
      retry     = 1'b0;
      case (state)
         S_IDLE:     if (!EMPTY) state_nxt = S_REQ;
         S_REQ:      if (ack_s) state_nxt = S_REL;
         S_REL:      if (!ack_s) state_nxt = S_WAIT_RES;
         S_WAIT_RES: if (succ_s || fail_s) state_nxt = S_RES_CLR;
         S_RES_CLR: begin
            if (!succ_s && !fail_s) begin
               if (res_fail && (retry_cnt < RW'(MAX_RETRY))) begin
                  retry     = 1'b1;
                  state_nxt = S_REQ;
               end else begin
                  state_nxt = S_RETIRE;
               end
            end
         end
         S_RETIRE: begin
            retire    = 1'b1;
            state_nxt = S_IDLE;
         end
         default:    state_nxt = S_IDLE;
      endcase
   end

   // Handshake outputs are flopped from the next state so the node never
   // sees decode glitches on REQ/TX_ACK.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state     <= S_IDLE;
         REQ_OUT   <= 1'b0;
         TX_ACK    <= 1'b0;
         DONE      <= 1'b0;
         DONE_FAIL <= 1'b0;
         res_fail  <= 1'b0;
         retry_cnt <= '0;
      end else begin
         state     <= state_nxt;
         REQ_OUT   <= (state_nxt == S_REQ);
         TX_ACK    <= (state_nxt == S_RES_CLR);
         DONE      <= (state_nxt == S_RETIRE);
         DONE_FAIL <= (state_nxt == S_RETIRE) && res_fail;
         if ((state == S_WAIT_RES) && (succ_s || fail_s)) res_fail <= fail_s;
         if (retry) retry_cnt <= retry_cnt + RW'(1);
         else if (retire) retry_cnt <= '0;
      end
   end

   always_comb begin
      count_nxt = count_q;
      if (push_ok && !retire) count_nxt = count_q + CW'(1);
      else if (!push_ok && retire) count_nxt = count_q - CW'(1);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         wptr     <= '0;
         rptr     <= '0;
         count_q  <= '0;
         FULL     <= 1'b0;
         EMPTY    <= 1'b1;
         OVERFLOW <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_addr[i] <= '0;
            mem_data[i] <= '0;
         end
      end else begin
         if (push_ok) begin
            mem_addr[wptr] <= PUSH_ADDR;
            mem_data[wptr] <= PUSH_DATA;
            wptr           <= wptr + PW'(1);
         end
         if (retire) rptr <= rptr + PW'(1);
         count_q  <= count_nxt;
         FULL     <= (count_nxt == CW'(DEPTH));
         EMPTY    <= (count_nxt == '0);
         OVERFLOW <= PUSH && FULL;
      end
   end

endmodule

// File: tb/tb_ulpb_tx_queue.sv
// Scoreboard bench for ulpb_tx_queue with a behavioural node on the far side.
module tb_ulpb_tx_queue;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        PUSH = 1'b0;
   logic [7:0]  PUSH_ADDR = '0;
   logic [31:0] PUSH_DATA = '0;
   logic        FULL, EMPTY, OVERFLOW, REQ_OUT, TX_ACK, DONE, DONE_FAIL;
   logic [2:0]  COUNT;
   logic [7:0]  ADDR_OUT;
   logic [31:0] DATA_OUT;
   logic        ACK_IN = 1'b0;
   logic        TX_SUCCESS = 1'b0;
   logic        TX_FAIL = 1'b0;

   always #5 CLK = ~CLK;

   ulpb_tx_queue #(.DEPTH(4), .ADDR_W(8), .DATA_W(32), .MAX_RETRY(2)) dut (
      .CLK(CLK), .RESET(RESET), .PUSH(PUSH), .PUSH_ADDR(PUSH_ADDR),
      .PUSH_DATA(PUSH_DATA), .FULL(FULL), .EMPTY(EMPTY), .COUNT(COUNT),
      .OVERFLOW(OVERFLOW), .ADDR_OUT(ADDR_OUT), .DATA_OUT(DATA_OUT),
      .REQ_OUT(REQ_OUT), .ACK_IN(ACK_IN), .TX_SUCCESS(TX_SUCCESS),
      .TX_FAIL(TX_FAIL), .TX_ACK(TX_ACK), .DONE(DONE), .DONE_FAIL(DONE_FAIL)
   );

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
      logic        fail;
      int          att;
   } exp_t;

   exp_t exp_q[$];
   bit   fail_q[$];
   int   checks = 0;
   int   failures = 0;
   bit   hold_ack = 1'b0;
   bit   hold_res = 1'b0;
   int   node_st = 0;
   int   mon_att = 0;
   bit   mon_req_prev = 1'b0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endfunction

   // Node: acks each REQ, then answers with FAIL or SUCCESS from fail_q.
   initial begin
      bit f;
      forever begin
         @(negedge CLK);
         if (RESET) begin
            ACK_IN = 1'b0; TX_SUCCESS = 1'b0; TX_FAIL = 1'b0; node_st = 0;
         end else begin
            case (node_st)
               0: if (REQ_OUT && !hold_ack) begin ACK_IN = 1'b1; node_st = 1; end
               1: if (!REQ_OUT) begin ACK_IN = 1'b0; node_st = 2; end
               2: if (!hold_res) begin
                     f = 1'b0;
                     if (fail_q.size() > 0) f = fail_q.pop_front();
                     if (f) TX_FAIL = 1'b1;
                     else TX_SUCCESS = 1'b1;
                     node_st = 3;
                  end
               3: if (TX_ACK) begin TX_FAIL = 1'b0; TX_SUCCESS = 1'b0; node_st = 4; end
               4: if (!TX_ACK) node_st = 0;
               default: node_st = 0;
            endcase
         end
      end
   end

   // Monitor: counts REQ attempts and checks every retirement against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (RESET) begin
            mon_att = 0; mon_req_prev = 1'b0;
         end else begin
            if (REQ_OUT && !mon_req_prev) mon_att++;
            mon_req_prev = REQ_OUT;
            if (REQ_OUT && TX_ACK) begin
               checks++; failures++;
               $display("FAIL handshake actual=REQ_OUT&TX_ACK required=exclusive");
            end
            if (DONE) begin
               if (exp_q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL done_unexpected actual=DONE required=no_done");
               end else begin
                  e = exp_q.pop_front();
                  chk("done_addr", 64'(ADDR_OUT), 64'(e.addr));
                  chk("done_data", 64'(DATA_OUT), 64'(e.data));
                  chk("done_fail", 64'(DONE_FAIL), 64'(e.fail));
                  chk("done_attempts", 64'(mon_att), 64'(e.att));
               end
               mon_att = 0;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic do_push(input logic [7:0] a, input logic [31:0] d);
      PUSH = 1'b1; PUSH_ADDR = a; PUSH_DATA = d;
      @(negedge CLK);
      PUSH = 1'b0;
   endtask

   task automatic wait_drain(input int max_cyc);
      int n = 0;
      while ((exp_q.size() != 0 || !EMPTY || REQ_OUT || TX_ACK) && n < max_cyc) begin
         @(negedge CLK);
         n++;
      end
      chk("drain_in_time", 64'(n < max_cyc), 64'(1));
      chk("drain_count", 64'(COUNT), 64'(0));
   endtask

   initial begin
      int n;
      repeat (3) @(negedge CLK);
      chk("rst_req", 64'(REQ_OUT), 64'(0));
      chk("rst_txack", 64'(TX_ACK), 64'(0));
      chk("rst_done", 64'(DONE), 64'(0));
      chk("rst_done_fail", 64'(DONE_FAIL), 64'(0));
      chk("rst_overflow", 64'(OVERFLOW), 64'(0));
      chk("rst_full", 64'(FULL), 64'(0));
      chk("rst_empty", 64'(EMPTY), 64'(1));
      chk("rst_count", 64'(COUNT), 64'(0));
      chk("rst_addr", 64'(ADDR_OUT), 64'(0));
      chk("rst_data", 64'(DATA_OUT), 64'(0));
      RESET = 1'b0;
      @(negedge CLK);

      // single message and first-request latency
      exp_q.push_back('{8'hAB, 32'h12345678, 1'b0, 1});
      do_push(8'hAB, 32'h12345678);
      chk("first_empty", 64'(EMPTY), 64'(0));
      chk("first_count", 64'(COUNT), 64'(1));
      chk("first_req_early", 64'(REQ_OUT), 64'(0));
      @(negedge CLK);
      chk("first_req", 64'(REQ_OUT), 64'(1));
      chk("first_addr", 64'(ADDR_OUT), 64'(8'hAB));
      chk("first_data", 64'(DATA_OUT), 64'(32'h12345678));
      wait_drain(100);

      // fill and overflow while the node withholds ACK
      hold_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back('{8'(8'h10 + i), 32'(32'hA0 + i), 1'b0, 1});
         do_push(8'(8'h10 + i), 32'(32'hA0 + i));
         chk("fill_count", 64'(COUNT), 64'(i + 1));
         chk("fill_full", 64'(FULL), 64'(i == 3));
      end
      do_push(8'hEE, 32'hDEADBEEF);
      chk("ovf_pulse", 64'(OVERFLOW), 64'(1));
      chk("ovf_count", 64'(COUNT), 64'(4));
      chk("ovf_full", 64'(FULL), 64'(1));
      @(negedge CLK);
      chk("ovf_clear", 64'(OVERFLOW), 64'(0));
      hold_ack = 1'b0;
      wait_drain(400);

      // one failure then success
      fail_q.push_back(1'b1);
      exp_q.push_back('{8'h21, 32'h0BADF00D, 1'b0, 2});
      do_push(8'h21, 32'h0BADF00D);
      wait_drain(200);

      // three failures exhaust retries, next entry then goes through
      repeat (3) fail_q.push_back(1'b1);
      exp_q.push_back('{8'h31, 32'h11110000, 1'b1, 3});
      exp_q.push_back('{8'h32, 32'h22220000, 1'b0, 1});
      do_push(8'h31, 32'h11110000);
      do_push(8'h32, 32'h22220000);
      wait_drain(400);
      chk("fail_q_used", 64'(fail_q.size()), 64'(0));

      // wrap-around with data 0..9
      for (int i = 0; i < 10; i++) begin
         n = 0;
         while (FULL && n < 200) begin
            @(negedge CLK);
            n++;
         end
         chk("wrap_space", 64'(n < 200), 64'(1));
         exp_q.push_back('{8'(8'h40 + i), 32'(i), 1'b0, 1});
         do_push(8'(8'h40 + i), 32'(i));
      end
      wait_drain(800);

      // reset while waiting for the result with 3 entries queued
      hold_res = 1'b1;
      do_push(8'h51, 32'h51);
      do_push(8'h52, 32'h52);
      do_push(8'h53, 32'h53);
      n = 0;
      while (node_st != 2 && n < 100) begin
         @(negedge CLK);
         n++;
      end
      chk("mid_reached", 64'(n < 100), 64'(1));
      repeat (4) @(negedge CLK);
      chk("mid_pre_count", 64'(COUNT), 64'(3));
      #2 RESET = 1'b1;
      #1;
      chk("mid_req", 64'(REQ_OUT), 64'(0));
      chk("mid_txack", 64'(TX_ACK), 64'(0));
      chk("mid_empty", 64'(EMPTY), 64'(1));
      chk("mid_count", 64'(COUNT), 64'(0));
      hold_res = 1'b0;
      fail_q.delete();
      repeat (2) @(negedge CLK);
      RESET = 1'b0;
      @(negedge CLK);

      // queue is usable again after the reset
      exp_q.push_back('{8'h5A, 32'hCAFEF00D, 1'b0, 1});
      do_push(8'h5A, 32'hCAFEF00D);
      wait_drain(200);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
